// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers.
package pipe_pkg;

    // Encoding of eret. Decode raises in_exempt for it so that an
    // interrupt clear does not squash it.
    localparam logic [31:0] ERET_INSTR = 32'h42000018;

    // Occupancy encodings of a pipeline stage register.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        STATE_EMPTY = ST_EMPTY,
        STATE_ONE   = ST_ONE,
        STATE_TWO   = ST_TWO
    } stage_state_e;

    // Field offsets inside the D/E payload. The pc8 field sits above the
    // four 32-bit words when a stage carries it, which widens DATA_W to 160.
    localparam int REG2_LSB   = 0;
    localparam int REG1_LSB   = 32;
    localparam int EXTIMM_LSB = 64;
    localparam int INSTR_LSB  = 96;
    localparam int PC8_LSB    = 128;

    // True when an instruction word is eret.
    function automatic logic isEret(input logic [31:0] instr);
        return instr == ERET_INSTR;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One {valid, exempt, data} slot of a stage register. Clearing zeroes the
// payload except for KEEP_MASK bits, which either hold or take keep_data_i.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int              DATA_W    = 128,
    parameter logic [DATA_W-1:0] KEEP_MASK = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              keep_load_i,
    input  logic              exempt_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] keep_data_i,
    output logic              valid_o,
    output logic              exempt_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q,  valid_d;
    logic              exempt_q, exempt_d;
    logic [DATA_W-1:0] data_q,   data_d;

    // Next slot contents: clear wins over load, otherwise hold.
    always_comb begin
        valid_d  = valid_q;
        exempt_d = exempt_q;
        data_d   = data_q;
        if (clear_i) begin
            valid_d  = 1'b0;
            exempt_d = 1'b0;
            data_d   = (keep_load_i ? keep_data_i : data_q) & KEEP_MASK;
        end else if (load_i) begin
            valid_d  = 1'b1;
            exempt_d = exempt_i;
            data_d   = data_i;
        end
    end

    // Slot register; reset wipes everything including kept bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            exempt_q <= 1'b0;
            data_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            exempt_q <= exempt_d;
            data_q   <= data_d;
        end
    end

    assign valid_o  = valid_q;
    assign exempt_o = exempt_q;
    assign data_o   = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer, flush,
// interrupt clear with eret exemption, and a saturating bubble counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 128,
    parameter logic [DATA_W-1:0] KEEP_MASK = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              intclr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_exempt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_exempt,
    output logic [CNT_W-1:0]  bubble_cnt,
    input  logic              bubble_clr
);

    logic              mainValid, mainExempt;
    logic [DATA_W-1:0] mainData;
    logic              skidValid, skidExempt;
    logic [DATA_W-1:0] skidData;

    logic              mainNextValid, mainNextExempt;
    logic [DATA_W-1:0] mainNextData;
    logic              skidNextValid, skidNextExempt;
    logic [DATA_W-1:0] skidNextData;

    logic              c0Valid, c0Exempt, c1Valid, c1Exempt;
    logic [DATA_W-1:0] c0Data, c1Data;
    logic              accept, dequeue, inKept;

    logic              inReady_q, inReady_d;
    logic [CNT_W-1:0]  bubbleCnt_q, bubbleCnt_d;
    stage_state_e      state;

    // Occupancy derived from the two valid bits (skid valid implies main valid).
    always_comb begin
        state = STATE_EMPTY;
        if (mainValid && skidValid) state = STATE_TWO;
        else if (mainValid)         state = STATE_ONE;
    end

    // Next contents of both slots: dequeue first, then drop non-exempt
    // entries on intclr, compact survivors and the incoming beat toward main,
    // and finally let flush wipe everything.
    always_comb begin
        accept   = in_valid && inReady_q;
        dequeue  = mainValid && out_ready;
        inKept   = accept && (!intclr || in_exempt);

        c0Valid  = 1'b0;
        c0Exempt = 1'b0;
        c0Data   = '0;
        c1Valid  = 1'b0;
        c1Exempt = 1'b0;
        c1Data   = '0;
        case (state)
            STATE_ONE: begin
                if (!dequeue) begin
                    c0Valid = 1'b1; c0Exempt = mainExempt; c0Data = mainData;
                end
            end
            STATE_TWO: begin
                if (dequeue) begin
                    c0Valid = 1'b1; c0Exempt = skidExempt; c0Data = skidData;
                end else begin
                    c0Valid = 1'b1; c0Exempt = mainExempt; c0Data = mainData;
                    c1Valid = 1'b1; c1Exempt = skidExempt; c1Data = skidData;
                end
            end
            default: ;
        endcase

        if (intclr) begin
            c0Valid = c0Valid && c0Exempt;
            c1Valid = c1Valid && c1Exempt;
        end

        mainNextValid  = 1'b0;
        mainNextExempt = 1'b0;
        mainNextData   = '0;
        skidNextValid  = 1'b0;
        skidNextExempt = 1'b0;
        skidNextData   = '0;
        if (c0Valid) begin
            mainNextValid = 1'b1; mainNextExempt = c0Exempt; mainNextData = c0Data;
            if (c1Valid) begin
                skidNextValid = 1'b1; skidNextExempt = c1Exempt; skidNextData = c1Data;
            end else if (inKept) begin
                skidNextValid = 1'b1; skidNextExempt = in_exempt; skidNextData = in_data;
            end
        end else if (c1Valid) begin
            mainNextValid = 1'b1; mainNextExempt = c1Exempt; mainNextData = c1Data;
            if (inKept) begin
                skidNextValid = 1'b1; skidNextExempt = in_exempt; skidNextData = in_data;
            end
        end else if (inKept) begin
            mainNextValid = 1'b1; mainNextExempt = in_exempt; mainNextData = in_data;
        end

        if (flush) begin
            mainNextValid = 1'b0;
            skidNextValid = 1'b0;
        end

        inReady_d = !skidNextValid;
    end

    pipe_entry #(.DATA_W(DATA_W), .KEEP_MASK(KEEP_MASK)) uMain (
        .clk         (clk),
        .reset       (reset),
        .load_i      (mainNextValid),
        .clear_i     (!mainNextValid),
        .keep_load_i (flush && in_valid),
        .exempt_i    (mainNextExempt),
        .data_i      (mainNextData),
        .keep_data_i (in_data),
        .valid_o     (mainValid),
        .exempt_o    (mainExempt),
        .data_o      (mainData)
    );

    pipe_entry #(.DATA_W(DATA_W), .KEEP_MASK(KEEP_MASK)) uSkid (
        .clk         (clk),
        .reset       (reset),
        .load_i      (skidNextValid),
        .clear_i     (!skidNextValid),
        .keep_load_i (1'b0),
        .exempt_i    (skidNextExempt),
        .data_i      (skidNextData),
        .keep_data_i ({DATA_W{1'b0}}),
        .valid_o     (skidValid),
        .exempt_o    (skidExempt),
        .data_o      (skidData)
    );

    // Bubble counter: clear wins, otherwise count empty cycles up to all-ones.
    always_comb begin
        bubbleCnt_d = bubbleCnt_q;
        if (bubble_clr)                              bubbleCnt_d = '0;
        else if (!mainValid && bubbleCnt_q != '1)    bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
    end

    // Registered ready and bubble count so upstream never sees an in-to-out path.
    always_ff @(posedge clk) begin
        if (reset) begin
            inReady_q   <= 1'b1;
            bubbleCnt_q <= '0;
        end else begin
            inReady_q   <= inReady_d;
            bubbleCnt_q <= bubbleCnt_d;
        end
    end

    assign in_ready   = inReady_q;
    assign out_valid  = mainValid;
    assign out_data   = mainData;
    assign out_exempt = mainExempt;
    assign bubble_cnt = bubbleCnt_q;

    // A stalled upstream beat must be held steady until it is taken.
    stallHold: assert property (@(posedge clk) disable iff (reset)
        (in_valid && !in_ready && !flush && !intclr) |=> (in_valid && $stable(in_data)));

endmodule
